// File: rtl/mask_frame_stats.sv
// mask_frame_stats
//   Per-frame masked-pixel statistics and fish-passage tracker. Counts the
//   masked pixels of each frame and publishes the count at frame end. With
//   MASK_BBOX_EN defined it also publishes the bounding box of those pixels.
//   A hysteresis FSM turns the per-frame counts into present/absent status
//   and a passage count.
//
//   Optional feature macro: MASK_BBOX_EN (bounding-box tracking). When it is
//   undefined, no bbox registers exist and bbox_* are tied to 0.
//
// Ports
//   clk, rst_n            pixel clock, async active-low reset
//   pix_en, mask          pixel qualifier and mask bit
//   tv_x, tv_y            raster coordinates of the pixel
//   frame_end             one-cycle pulse that closes the current frame
//   thr_on, thr_off       enter (>=) and exit (<) count thresholds
//   min_frames            consecutive frames to confirm a transition (0 acts as 1)
//   pix_count, bbox_*     statistics of the last closed frame
//   bbox_valid            last closed frame had at least one masked pixel
//   stats_valid           one-cycle pulse when the statistics update
//   present, fish_count   object status and passages since reset
module mask_frame_stats #(
  parameter int CNT_W  = 20,
  parameter int FISH_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  input  logic              mask,
  input  logic [9:0]        tv_x,
  input  logic [9:0]        tv_y,
  input  logic              frame_end,
  input  logic [CNT_W-1:0]  thr_on,
  input  logic [CNT_W-1:0]  thr_off,
  input  logic [3:0]        min_frames,
  output logic [CNT_W-1:0]  pix_count,
  output logic [9:0]        bbox_x0,
  output logic [9:0]        bbox_x1,
  output logic [9:0]        bbox_y0,
  output logic [9:0]        bbox_y1,
  output logic              bbox_valid,
  output logic              stats_valid,
  output logic              present,
  output logic [FISH_W-1:0] fish_count
);

  typedef enum logic [1:0] {S_IDLE, S_ENTER, S_PRESENT, S_EXIT} state_e;

  logic hit;
  assign hit = pix_en & mask;

  // Count including this cycle's pixel, so a pixel coincident with
  // frame_end lands in the closing frame.
  logic [CNT_W-1:0] acc_cnt_q, cnt_d;
  assign cnt_d = (hit && (acc_cnt_q != '1)) ? acc_cnt_q + 1'b1 : acc_cnt_q;

  logic [CNT_W-1:0] pix_count_q;
  logic             bbox_valid_q, stats_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_q     <= '0;
      pix_count_q   <= '0;
      bbox_valid_q  <= 1'b0;
      stats_valid_q <= 1'b0;
    end else begin
      stats_valid_q <= frame_end;
      if (frame_end) begin
        acc_cnt_q    <= '0;
        pix_count_q  <= cnt_d;
        bbox_valid_q <= (cnt_d != '0);
      end else begin
        acc_cnt_q <= cnt_d;
      end
    end
  end

  assign pix_count   = pix_count_q;
  assign bbox_valid  = bbox_valid_q;
  assign stats_valid = stats_valid_q;

`ifdef MASK_BBOX_EN
  logic [9:0] acc_x0_q, acc_x1_q, acc_y0_q, acc_y1_q;
  logic [9:0] x0_d, x1_d, y0_d, y1_d;
  logic [9:0] bbox_x0_q, bbox_x1_q, bbox_y0_q, bbox_y1_q;

  assign x0_d = (hit && tv_x < acc_x0_q) ? tv_x : acc_x0_q;
  assign x1_d = (hit && tv_x > acc_x1_q) ? tv_x : acc_x1_q;
  assign y0_d = (hit && tv_y < acc_y0_q) ? tv_y : acc_y0_q;
  assign y1_d = (hit && tv_y > acc_y1_q) ? tv_y : acc_y1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_x0_q  <= 10'd1023;
      acc_y0_q  <= 10'd1023;
      acc_x1_q  <= '0;
      acc_y1_q  <= '0;
      bbox_x0_q <= '0;
      bbox_x1_q <= '0;
      bbox_y0_q <= '0;
      bbox_y1_q <= '0;
    end else if (frame_end) begin
      acc_x0_q <= 10'd1023;
      acc_y0_q <= 10'd1023;
      acc_x1_q <= '0;
      acc_y1_q <= '0;
      // Empty frame: the accumulators hold their empty sentinels, report 0.
      if (cnt_d != '0) begin
        bbox_x0_q <= x0_d;
        bbox_x1_q <= x1_d;
        bbox_y0_q <= y0_d;
        bbox_y1_q <= y1_d;
      end else begin
        bbox_x0_q <= '0;
        bbox_x1_q <= '0;
        bbox_y0_q <= '0;
        bbox_y1_q <= '0;
      end
    end else begin
      acc_x0_q <= x0_d;
      acc_x1_q <= x1_d;
      acc_y0_q <= y0_d;
      acc_y1_q <= y1_d;
    end
  end

  assign bbox_x0 = bbox_x0_q;
  assign bbox_x1 = bbox_x1_q;
  assign bbox_y0 = bbox_y0_q;
  assign bbox_y1 = bbox_y1_q;
`else
  assign bbox_x0 = '0;
  assign bbox_x1 = '0;
  assign bbox_y0 = '0;
  assign bbox_y1 = '0;
`endif

  // Hysteresis FSM, stepped once per frame close.
  state_e            state_q, state_d;
  logic [3:0]        q_q, q_d, q_inc, mf;
  logic [FISH_W-1:0] fish_q, fish_d;
  logic              hi, lo;

  assign mf    = (min_frames == 4'd0) ? 4'd1 : min_frames;
  assign q_inc = q_q + 4'd1;
  assign hi    = (cnt_d >= thr_on);
  assign lo    = (cnt_d < thr_off);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    fish_d  = fish_q;
    if (frame_end) begin
      unique case (state_q)
        S_IDLE: begin
          q_d = '0;
          if (hi) begin
            if (mf == 4'd1) state_d = S_PRESENT;
            else begin
              state_d = S_ENTER;
              q_d     = 4'd1;
            end
          end
        end
        S_ENTER: begin
          if (!hi) begin
            state_d = S_IDLE;
            q_d     = '0;
          end else if (q_inc >= mf) begin
            // >= so a min_frames reduced mid-run still terminates.
            state_d = S_PRESENT;
            q_d     = '0;
          end else begin
            q_d = q_inc;
          end
        end
        S_PRESENT: begin
          q_d = '0;
          if (lo) begin
            if (mf == 4'd1) begin
              state_d = S_IDLE;
              fish_d  = fish_q + 1'b1;
            end else begin
              state_d = S_EXIT;
              q_d     = 4'd1;
            end
          end
        end
        S_EXIT: begin
          if (!lo) begin
            state_d = S_PRESENT;
            q_d     = '0;
          end else if (q_inc >= mf) begin
            state_d = S_IDLE;
            q_d     = '0;
            fish_d  = fish_q + 1'b1;
          end else begin
            q_d = q_inc;
          end
        end
        default: begin
          state_d = S_IDLE;
          q_d     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      fish_q  <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      fish_q  <= fish_d;
    end
  end

  assign present    = (state_q == S_PRESENT) || (state_q == S_EXIT);
  assign fish_count = fish_q;

endmodule
